pc_redirect_ctrl: RTL and testbench

//  Sequences the next-PC unit: owns the PC register, picks the NPCOp each cycle and arbitrates redirect sources.

---
 rtl/pc_redirect_ctrl_pkg.sv | 25 ++
 rtl/pc_redirect_ctrl_prio_enc.sv | 48 ++++
 rtl/pc_redirect_ctrl.sv | 108 ++++++++++
 tb/tb_pc_redirect_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// ============================================================================
// Module      : pc_redirect_ctrl_pkg
// Description : NPCOp encodings and redirect-controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_redirect_ctrl_pkg;

    localparam int unsigned NPC_OP_W = 2;

    localparam logic [NPC_OP_W-1:0] NPC_PLUS4    = 2'b00;
    localparam logic [NPC_OP_W-1:0] NPC_BRANCH   = 2'b01;
    localparam logic [NPC_OP_W-1:0] NPC_JUMP_IMM = 2'b10;
    localparam logic [NPC_OP_W-1:0] NPC_JUMP_REG = 2'b11;

    typedef enum logic [1:0] {
        PCR_S_RESET = 2'd0,
        PCR_S_FETCH = 2'd1,
        PCR_S_HOLD  = 2'd2
    } pcr_state_e;

endpackage : pc_redirect_ctrl_pkg

`default_nettype wire

// File: rtl/pc_redirect_ctrl_prio_enc.sv
// ============================================================================
// Module      : pcr_prio_enc
// Description : Redirect source priority -> NPCOp and flush requests.
//               Macro NPC_DELAY_SLOT_EN: jumps do not squash IF/ID and
//               branches squash ID/EX only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcr_prio_enc
    import pc_redirect_ctrl_pkg::*;
(
    input  logic                branch_i,
    input  logic                jump_reg_i,
    input  logic                jump_imm_i,
    output logic [NPC_OP_W-1:0] npc_op_o,
    output logic                flush_if_id_o,
    output logic                flush_id_ex_o
);

`ifdef NPC_DELAY_SLOT_EN
    localparam logic JUMP_FLUSH_IF_ID   = 1'b0;
    localparam logic BRANCH_FLUSH_IF_ID = 1'b0;
`else
    localparam logic JUMP_FLUSH_IF_ID   = 1'b1;
    localparam logic BRANCH_FLUSH_IF_ID = 1'b1;
`endif

    always_comb begin
        npc_op_o      = NPC_PLUS4;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        if (branch_i) begin
            npc_op_o      = NPC_BRANCH;
            flush_if_id_o = BRANCH_FLUSH_IF_ID;
            flush_id_ex_o = 1'b1;
        end else if (jump_reg_i) begin
            npc_op_o      = NPC_JUMP_REG;
            flush_if_id_o = JUMP_FLUSH_IF_ID;
        end else if (jump_imm_i) begin
            npc_op_o      = NPC_JUMP_IMM;
            flush_if_id_o = JUMP_FLUSH_IF_ID;
        end
    end

endmodule : pcr_prio_enc

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Owns the fetch PC, selects the NPCOp and parks a redirect
//               target while the instruction fetch is still outstanding.
//               Optional macro NPC_DELAY_SLOT_EN (see pcr_prio_enc).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                ex_branch_taken,
    input  logic                id_jump_reg,
    input  logic                id_jump_imm,
    input  logic                imem_ready,
    input  logic [PC_W-1:0]     npc,
    output logic [NPC_OP_W-1:0] npc_op,
    output logic [PC_W-1:0]     pc,
    output logic                imem_req,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                redirect_pending
);

    pcr_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

    logic            in_fetch, in_hold;
    logic            src_branch, src_jump_reg, src_jump_imm, redirect;
    logic            release_flush;
    logic            enc_flush_if_id;

    assign in_fetch = (state_q == PCR_S_FETCH);
    assign in_hold  = (state_q == PCR_S_HOLD);

    // Jumps are masked under stall (ID re-presents them) and while a target is parked.
    assign src_branch   = ex_branch_taken & (in_fetch | in_hold);
    assign src_jump_reg = id_jump_reg & ~stall & in_fetch;
    assign src_jump_imm = id_jump_imm & ~stall & in_fetch;
    assign redirect     = src_branch | src_jump_reg | src_jump_imm;

    pcr_prio_enc u_prio_enc (
        .branch_i      (src_branch),
        .jump_reg_i    (src_jump_reg),
        .jump_imm_i    (src_jump_imm),
        .npc_op_o      (npc_op),
        .flush_if_id_o (enc_flush_if_id),
        .flush_id_ex_o (flush_id_ex)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_tgt_d    = pend_tgt_q;
        release_flush = 1'b0;
        unique case (state_q)
            PCR_S_RESET: state_d = PCR_S_FETCH;
            PCR_S_FETCH: begin
                if (imem_ready && !(stall && !ex_branch_taken)) begin
                    pc_d = npc;
                end else if (redirect && !imem_ready) begin
                    pend_tgt_d = npc;
                    state_d    = PCR_S_HOLD;
                end
            end
            PCR_S_HOLD: begin
                // A branch in EX is older than the parked redirect, so it replaces it.
                if (ex_branch_taken) begin
                    pend_tgt_d = npc;
                end
                if (imem_ready) begin
                    pc_d          = ex_branch_taken ? npc : pend_tgt_q;
                    release_flush = 1'b1;
                    state_d       = PCR_S_FETCH;
                end
            end
            default: state_d = PCR_S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PCR_S_RESET;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc               = pc_q;
    assign imem_req         = in_fetch | in_hold;
    assign redirect_pending = in_hold;
    assign flush_if_id      = enc_flush_if_id | release_flush;

endmodule : pc_redirect_ctrl

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ============================================================================
// Module      : tb_pc_redirect_ctrl
// Description : Directed self-checking bench for pc_redirect_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_branch_taken;
    logic        id_jump_reg;
    logic        id_jump_imm;
    logic        imem_ready;
    logic [31:0] npc;
    logic [1:0]  npc_op;
    logic [31:0] pc;
    logic        imem_req;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        redirect_pending;

    int checks   = 0;
    int failures = 0;

`ifdef NPC_DELAY_SLOT_EN
    localparam logic EXP_JUMP_FIF   = 1'b0;
    localparam logic EXP_BRANCH_FIF = 1'b0;
`else
    localparam logic EXP_JUMP_FIF   = 1'b1;
    localparam logic EXP_BRANCH_FIF = 1'b1;
`endif

    pc_redirect_ctrl #(
        .PC_W     (32),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_branch_taken  (ex_branch_taken),
        .id_jump_reg      (id_jump_reg),
        .id_jump_imm      (id_jump_imm),
        .imem_ready       (imem_ready),
        .npc              (npc),
        .npc_op           (npc_op),
        .pc               (pc),
        .imem_req         (imem_req),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic br, input logic jr, input logic ji,
                         input logic rdy, input logic [31:0] tgt);
        stall           = st;
        ex_branch_taken = br;
        id_jump_reg     = jr;
        id_jump_imm     = ji;
        imem_ready      = rdy;
        npc             = tgt;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
        tick();
        check("rst_pc",      pc,               32'h0000_3000);
        check("rst_req",     imem_req,         0);
        check("rst_op",      npc_op,           0);
        check("rst_fif",     flush_if_id,      0);
        check("rst_fie",     flush_id_ex,      0);
        check("rst_pend",    redirect_pending, 0);

        // Sequential fetch
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 32'h0000_3004);
        check("c1_req",      imem_req,         0);
        tick();
        check("c2_req",      imem_req,         1);
        check("c2_pc",       pc,               32'h0000_3000);
        drive(0, 0, 0, 0, 1, 32'h0000_3004);
        tick();
        check("seq_pc1",     pc,               32'h0000_3004);
        drive(0, 0, 0, 0, 1, 32'h0000_3008);
        tick();
        check("seq_pc2",     pc,               32'h0000_3008);
        drive(0, 0, 0, 0, 1, 32'h0000_300C);
        tick();
        check("seq_pc3",     pc,               32'h0000_300C);

        // Branch beats jump-imm in the same cycle
        drive(0, 1, 0, 1, 1, 32'h0000_2000);
        check("bj_op",       npc_op,           2'b01);
        check("bj_fif",      flush_if_id,      EXP_BRANCH_FIF);
        check("bj_fie",      flush_id_ex,      1);
        tick();
        check("bj_pc",       pc,               32'h0000_2000);

        // Stall masks jump-reg and holds PC
        drive(1, 0, 1, 0, 1, 32'h0000_6000);
        check("st_op",       npc_op,           2'b00);
        check("st_fif",      flush_if_id,      0);
        tick();
        check("st_pc",       pc,               32'h0000_2000);
        drive(0, 0, 1, 0, 1, 32'h0000_6000);
        check("jr_op",       npc_op,           2'b11);
        check("jr_fif",      flush_if_id,      EXP_JUMP_FIF);
        check("jr_fie",      flush_id_ex,      0);
        tick();
        check("jr_pc",       pc,               32'h0000_6000);

        // Branch overrides stall
        drive(1, 1, 0, 0, 1, 32'h0000_7000);
        check("sb_op",       npc_op,           2'b01);
        tick();
        check("sb_pc",       pc,               32'h0000_7000);

        // Jump-imm while fetch outstanding -> hold
        drive(0, 0, 0, 1, 0, 32'h0000_4000);
        check("ji_op",       npc_op,           2'b10);
        check("ji_fif",      flush_if_id,      EXP_JUMP_FIF);
        check("ji_pend0",    redirect_pending, 0);
        tick();
        check("ji_pend1",    redirect_pending, 1);
        check("ji_pc_hold",  pc,               32'h0000_7000);
        drive(0, 0, 1, 0, 0, 32'h0000_9990);
        check("hold_jr_op",  npc_op,           2'b00);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0000_7004);
        tick();
        tick();
        check("hold_pend3",  redirect_pending, 1);
        check("hold_pc3",    pc,               32'h0000_7000);
        drive(0, 0, 0, 0, 1, 32'h0000_7004);
        check("rel_fif",     flush_if_id,      1);
        tick();
        check("rel_pc",      pc,               32'h0000_4000);
        check("rel_pend",    redirect_pending, 0);

        // Branch in hold overwrites parked target
        drive(0, 0, 0, 1, 0, 32'h0000_4000);
        tick();
        drive(0, 1, 0, 0, 0, 32'h0000_5000);
        check("hb_op",       npc_op,           2'b01);
        check("hb_fie",      flush_id_ex,      1);
        tick();
        check("hb_pend",     redirect_pending, 1);
        drive(0, 0, 0, 0, 1, 32'h0000_4004);
        tick();
        check("hb_pc",       pc,               32'h0000_5000);

        // Reset while holding discards the parked target
        drive(0, 0, 0, 1, 0, 32'h0000_8000);
        tick();
        check("rh_pend",     redirect_pending, 1);
        rst = 1'b1;
        tick();
        check("rh_pc",       pc,               32'h0000_3000);
        check("rh_pendclr",  redirect_pending, 0);
        check("rh_req",      imem_req,         0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 32'h0000_3004);
        tick();
        tick();
        check("rh_seq_pc",   pc,               32'h0000_3004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_redirect_ctrl

`default_nettype wire
